// File: rtl/sram_host_ctrl_if.sv
// Bundle of the command, write-data, response and sram_core-side signals of
// sram_host_ctrl.
//   master : the controller (drives cmd_ready, wr_ready, rsp_*, mem_enable,
//            mem_read_not_write, mem_addr, mem_wdata)
//   slave  : the environment (command decoder, write stream, response sink
//            and sram_core)
interface sram_host_ctrl_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 4,
    parameter int unsigned LEN_W  = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;

    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_last;
    logic              rsp_err;

    logic              mem_enable;
    logic              mem_read_not_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  wr_valid, wr_data,
        input  rsp_ready,
        input  mem_rdata, mem_ready,
        output cmd_ready, wr_ready,
        output rsp_valid, rsp_data, rsp_last, rsp_err,
        output mem_enable, mem_read_not_write, mem_addr, mem_wdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        output wr_valid, wr_data,
        output rsp_ready,
        output mem_rdata, mem_ready,
        input  cmd_ready, wr_ready,
        input  rsp_valid, rsp_data, rsp_last, rsp_err,
        input  mem_enable, mem_read_not_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/sram_host_ctrl.sv
// Host-side initiator for sram_core. Accepts single/burst read/write commands,
// pulls write data from a stream, runs one enable/hold/ready/gap access per
// beat and returns one response per beat with timeout reporting.
// Ports:
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   bus      : sram_host_ctrl_if.master (command, write data, response and
//              sram_core signals)
module sram_host_ctrl #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned DATA_W  = 4,
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    sram_host_ctrl_if.master    bus
);
    // Timer only ever holds 0..TIMEOUT-1.
    localparam int unsigned TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WDATA,
        S_ISSUE,
        S_RESP,
        S_GAP
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              write_q, write_d;
    logic              rnw_q, rnw_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              last_c;

    // Final response of the command: last beat, or an error that aborts it.
    assign last_c = (beat_cnt_q == len_q) || err_q;

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            beat_cnt_q <= '0;
            write_q    <= 1'b0;
            rnw_q      <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            timer_q    <= '0;
            wdata_q    <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
            write_q    <= write_d;
            rnw_q      <= rnw_d;
            done_q     <= done_d;
            err_q      <= err_d;
            timer_q    <= timer_d;
            wdata_q    <= wdata_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q;
        write_d    = write_q;
        rnw_d      = rnw_q;
        done_d     = done_q;
        err_d      = err_q;
        timer_d    = '0;          // cleared everywhere outside ISSUE
        wdata_d    = wdata_q;
        rsp_data_d = rsp_data_q;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    addr_d     = bus.cmd_addr;
                    len_d      = bus.cmd_len;
                    write_d    = bus.cmd_write;
                    rnw_d      = ~bus.cmd_write;
                    beat_cnt_d = '0;
                    done_d     = 1'b0;
                    state_d    = bus.cmd_write ? S_WDATA : S_ISSUE;
                end
            end
            S_WDATA: begin
                if (bus.wr_valid) begin
                    wdata_d = bus.wr_data;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // mem_ready takes priority over a timeout in the same cycle.
                if (bus.mem_ready) begin
                    rsp_data_d = write_q ? '0 : bus.mem_rdata;
                    err_d      = 1'b0;
                    state_d    = S_RESP;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    rsp_data_d = '0;
                    err_d      = 1'b1;
                    state_d    = S_RESP;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    done_d = last_c;
                    if (!last_c) begin
                        addr_d     = addr_q + ADDR_W'(1);
                        beat_cnt_d = beat_cnt_q + LEN_W'(1);
                    end
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                // One enable-low cycle so sram_core can return to idle.
                if (done_q)       state_d = S_IDLE;
                else if (write_q) state_d = S_WDATA;
                else              state_d = S_ISSUE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs decoded from registered state and datapath.
    assign bus.cmd_ready          = (state_q == S_IDLE);
    assign bus.wr_ready           = (state_q == S_WDATA);
    assign bus.mem_enable         = (state_q == S_ISSUE);
    assign bus.mem_addr           = addr_q;
    assign bus.mem_wdata          = wdata_q;
    assign bus.mem_read_not_write = rnw_q;
    assign bus.rsp_valid          = (state_q == S_RESP);
    assign bus.rsp_data           = rsp_data_q;
    assign bus.rsp_last           = (state_q == S_RESP) && last_c;
    assign bus.rsp_err            = (state_q == S_RESP) && err_q;

endmodule
